seg_hue_classifier: RTL and testbench
=====================================

// Module: seg_hue_classifier
// PURPOSE
//  Streaming multi-class hue segmenter: classifies each RGB pixel of a raster
//  into background (0) or one of N_CLASS hue classes and passes hcnt/vcnt
//  through with matched latency. Sits after video input, before mask
//  consumers (likelihood/particle stages).
//  Adds per-frame config shadowing and per-class pixel statistics latched at
//  end of frame.
// PARAMETERS
//  WIDTH    640  total pixels per line (hcnt wraps at WIDTH-1)
//  HEIGHT   480  total lines per frame (vcnt wraps at HEIGHT-1)
//  H_DISP   640  active pixels/line; hcnt >= H_DISP is blanking
//  V_DISP   480  active lines/frame; vcnt >= V_DISP is blanking
//  N_CLASS  3    number of hue classes (1..7)
//  HUE_TOL  8    max circular hue distance (degrees) for a class match
//  Localparams: CLASS_W = $clog2(N_CLASS+1); CNT_W = $clog2(H_DISP*V_DISP+1);
//   HC_W = $clog2(WIDTH+1); VC_W = $clog2(HEIGHT+1); LAT = 4.
// PORTS
//  clock     in   1           system clock, rising edge
//  n_rst     in   1           asynchronous active-low reset
//  in_y      in   24          pixel {R[23:16],G[15:8],B[7:0]}
//  in_hcnt   in   HC_W        horizontal count of in_y
//  in_vcnt   in   VC_W        vertical count of in_y
//  cfg_hue   in   N_CLASS*9   target hue per class, 0..359; class k at [9k+:9]
//  cfg_rmin  in   8           min value of max(R,G,B) to be foreground
//  out_y     out  CLASS_W     0 = background, k+1 = class k
//  out_hcnt  out  HC_W        in_hcnt delayed LAT cycles
//  out_vcnt  out  VC_W        in_vcnt delayed LAT cycles
//  stat_cnt  out  N_CLASS*CNT_W  class-k pixel count of last frame at [CNT_W*k+:CNT_W]
//  stat_valid out 1           one-cycle pulse when stat_cnt updates
// BEHAVIOUR
//  - Reset: all outputs 0; pipeline valid bits 0; shadow hues 0; shadow rmin 8'hFF.
//  - Latency: fixed LAT=4 clocks, in_* -> out_*, every cycle, no stalls.
//  - Out_y forced 0 while pipeline valid bit low, i.e. first LAT cycles after reset.
//  - Config: cfg_hue/cfg_rmin are sampled into shadow registers on the cycle
//    in_hcnt==0 && in_vcnt==0. That pixel and the rest of its frame use the new values.
//    Changes elsewhere have no effect until the next frame start.
//  - Hue (integer degrees): mx=max, mn=min, d=mx-mn; tie priority R>G>B for mx.
//    mx==R: h=60*(G-B)/d; mx==G: h=120+60*(B-R)/d; mx==B: h=240+60*(R-G)/d.
//    Division truncates toward zero; h<0 -> h+360. d==0 -> achromatic.
//  - Class k matches: mx>=rmin AND d!=0 AND min(|h-hue_k|, 360-|h-hue_k|)<=HUE_TOL.
//    out_y = (lowest matching k)+1, else 0.
//  - Blanking: pixels with hcnt>=H_DISP or vcnt>=V_DISP give out_y=0 and are not counted.
//  - Stats: per-class counters increment on valid active output pixels with
//    out_y==k+1.
//    On output pixel (H_DISP-1,V_DISP-1), stat_cnt <= counters incl. this pixel.
//    Same cycle: stat_valid=1 and counters clear to 0.
//    Counters saturate at all-ones (corrupt geometry). stat_cnt holds between frames.
//  - Reset mid-frame: pipeline flushed, counters cleared, no stat_valid until
//    the next complete end-of-frame pixel reaches the output.
// STRUCTURE
//  - Package segment_pkg: rgb_t struct {r,g,b}, HUE_MAX=360,
//    function hue_dist(a,b) (circular distance), class-code typedef.
//  - Sub-module seg_hue_calc: stages 1-3 (max/min/sector, 60*num, divide+wrap),
//    outputs hue[8:0], mx, achromatic.
//  - Top does shadowing, stage-4 classification, count delay line, statistics.
// TESTING
//  - in_y=FF0000, cfg_hue[0]=0, rmin=64 -> out_y=1 exactly 4 clocks later,
//    out_hcnt/vcnt match.
//  - 00FF00 with cfg_hue={240,120,0} -> out_y=2; 808080 -> 0; 300000 (mx 48<64) -> 0.
//  - Wrap: cfg_hue[0]=355, in_y=FF0010 (h=357) -> out_y=1; FF4000 (h=15) -> 0.
//  - Priority: cfg_hue[0]=cfg_hue[1]=0, in_y=FF0000 -> out_y=1, never 2.
//  - WIDTH=8,HEIGHT=4,H_DISP=6,V_DISP=3, all FF0000 -> stat_cnt[0]=18,
//    others 0, stat_valid pulses once per frame.
//    Same cycle: out (5,2).
//  - cfg_hue change mid-frame -> no effect until next (0,0).
//    n_rst low mid-frame -> outputs 0, no stat_valid until one full frame later.

Source files
------------

// File: rtl/segment_pkg.sv
// Shared types and helpers for the hue segmenter: pixel struct, class code
// and circular hue distance.
package segment_pkg;

  localparam int HUE_MAX = 360;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Wide enough for the largest supported class count (7) plus background.
  typedef logic [2:0] class_code_t;

  // Shortest distance between two hues on the 0..359 circle.
  function automatic logic [8:0] hue_dist(input logic [8:0] a, input logic [8:0] b);
    logic [8:0] diff;
    diff = (a > b) ? a - b : b - a;
    return (diff > 9'd180) ? 9'(HUE_MAX) - diff : diff;
  endfunction

endpackage

// File: rtl/seg_hue_calc.sv
// Three-stage integer hue pipeline: max/min/sector, 60*numerator, then
// truncating divide and wrap into 0..359.
module seg_hue_calc
  import segment_pkg::*;
(
  input  logic        clock,
  input  logic        n_rst,
  input  logic [23:0] pix,
  output logic [8:0]  hue,
  output logic [7:0]  mx,
  output logic        achromatic
);

  typedef enum logic [1:0] {SEC_R, SEC_G, SEC_B} sector_t;

  rgb_t              px;
  logic [7:0]        mx_c;
  logic [7:0]        mn_c;
  sector_t           sec_c;
  logic signed [8:0] num_c;

  assign px = pix;

  // Strict compares give the R > G > B tie priority for the maximum.
  always_comb begin
    mx_c  = px.r;
    sec_c = SEC_R;
    if (px.g > mx_c) begin
      mx_c  = px.g;
      sec_c = SEC_G;
    end
    if (px.b > mx_c) begin
      mx_c  = px.b;
      sec_c = SEC_B;
    end
    mn_c = px.r;
    if (px.g < mn_c) mn_c = px.g;
    if (px.b < mn_c) mn_c = px.b;
    case (sec_c)
      SEC_G:   num_c = $signed({1'b0, px.b}) - $signed({1'b0, px.r});
      SEC_B:   num_c = $signed({1'b0, px.r}) - $signed({1'b0, px.g});
      default: num_c = $signed({1'b0, px.g}) - $signed({1'b0, px.b});
    endcase
  end

  logic [7:0]         s1_mx, s1_d, s2_mx, s2_d;
  sector_t            s1_sec, s2_sec;
  logic signed [8:0]  s1_num;
  logic signed [14:0] s2_prod;
  logic signed [14:0] num_ext;
  logic signed [14:0] den;
  logic signed [14:0] quot;
  logic signed [10:0] base;
  logic signed [10:0] h_c;

  assign num_ext = {{6{s1_num[8]}}, s1_num};
  // A zero spread is flagged achromatic; the divisor is forced to 1 so the
  // divider never sees zero.
  assign den     = {7'd0, (s2_d == 8'd0) ? 8'd1 : s2_d};
  assign quot    = s2_prod / den;

  always_comb begin
    case (s2_sec)
      SEC_G:   base = 11'sd120;
      SEC_B:   base = 11'sd240;
      default: base = 11'sd0;
    endcase
    h_c = base + $signed(quot[10:0]);
    if (h_c < 11'sd0) h_c = h_c + 11'sd360;
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      s1_mx      <= '0;
      s1_d       <= '0;
      s1_sec     <= SEC_R;
      s1_num     <= '0;
      s2_mx      <= '0;
      s2_d       <= '0;
      s2_sec     <= SEC_R;
      s2_prod    <= '0;
      hue        <= '0;
      mx         <= '0;
      achromatic <= 1'b1;
    end else begin
      s1_mx      <= mx_c;
      s1_d       <= mx_c - mn_c;
      s1_sec     <= sec_c;
      s1_num     <= num_c;
      s2_mx      <= s1_mx;
      s2_d       <= s1_d;
      s2_sec     <= s1_sec;
      s2_prod    <= num_ext * 15'sd60;
      hue        <= h_c[8:0];
      mx         <= s2_mx;
      achromatic <= (s2_d == 8'd0);
    end
  end

endmodule

// File: rtl/seg_hue_classifier.sv
// Streaming hue segmenter: per-frame config shadowing, hue classification,
// matched-latency raster counts and per-class end-of-frame statistics.
module seg_hue_classifier
  import segment_pkg::*;
#(
  parameter  int WIDTH   = 640,
  parameter  int HEIGHT  = 480,
  parameter  int H_DISP  = 640,
  parameter  int V_DISP  = 480,
  parameter  int N_CLASS = 3,
  parameter  int HUE_TOL = 8,
  localparam int CLASS_W = $clog2(N_CLASS + 1),
  localparam int CNT_W   = $clog2(H_DISP * V_DISP + 1),
  localparam int HC_W    = $clog2(WIDTH + 1),
  localparam int VC_W    = $clog2(HEIGHT + 1)
) (
  input  logic                     clock,
  input  logic                     n_rst,
  input  logic [23:0]              in_y,
  input  logic [HC_W-1:0]          in_hcnt,
  input  logic [VC_W-1:0]          in_vcnt,
  input  logic [N_CLASS*9-1:0]     cfg_hue,
  input  logic [7:0]               cfg_rmin,
  output logic [CLASS_W-1:0]       out_y,
  output logic [HC_W-1:0]          out_hcnt,
  output logic [VC_W-1:0]          out_vcnt,
  output logic [N_CLASS*CNT_W-1:0] stat_cnt,
  output logic                     stat_valid
);

  logic                 sof_in;
  logic [N_CLASS*9-1:0] sh_hue, hue_sel;
  logic [7:0]           sh_rmin, rmin_sel;

  // The frame-start pixel itself already uses the freshly sampled config.
  assign sof_in   = (in_hcnt == '0) && (in_vcnt == '0);
  assign hue_sel  = sof_in ? cfg_hue : sh_hue;
  assign rmin_sel = sof_in ? cfg_rmin : sh_rmin;

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      sh_hue  <= '0;
      sh_rmin <= 8'hFF;
    end else if (sof_in) begin
      sh_hue  <= cfg_hue;
      sh_rmin <= cfg_rmin;
    end
  end

  logic [8:0] c_hue;
  logic [7:0] c_mx;
  logic       c_achrom;

  seg_hue_calc u_calc (
    .clock      (clock),
    .n_rst      (n_rst),
    .pix        (in_y),
    .hue        (c_hue),
    .mx         (c_mx),
    .achromatic (c_achrom)
  );

  // Side-band travels with each pixel so frame-boundary config changes never
  // leak onto the tail of the previous frame.
  logic [HC_W-1:0]      p_hcnt [3];
  logic [VC_W-1:0]      p_vcnt [3];
  logic [N_CLASS*9-1:0] p_hue  [3];
  logic [7:0]           p_rmin [3];
  logic [2:0]           p_valid;

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 3; i++) begin
        p_hcnt[i] <= '0;
        p_vcnt[i] <= '0;
        p_hue[i]  <= '0;
        p_rmin[i] <= 8'hFF;
      end
      p_valid <= '0;
    end else begin
      p_hcnt[0] <= in_hcnt;
      p_vcnt[0] <= in_vcnt;
      p_hue[0]  <= hue_sel;
      p_rmin[0] <= rmin_sel;
      for (int i = 1; i < 3; i++) begin
        p_hcnt[i] <= p_hcnt[i-1];
        p_vcnt[i] <= p_vcnt[i-1];
        p_hue[i]  <= p_hue[i-1];
        p_rmin[i] <= p_rmin[i-1];
      end
      p_valid <= {p_valid[1:0], 1'b1};
    end
  end

  logic               active4, sof4, eof4;
  logic [N_CLASS-1:0] hit;
  class_code_t        code;

  assign active4 = p_valid[2] && (p_hcnt[2] < HC_W'(H_DISP)) && (p_vcnt[2] < VC_W'(V_DISP));
  assign sof4    = p_valid[2] && (p_hcnt[2] == '0) && (p_vcnt[2] == '0);
  assign eof4    = p_valid[2] && (p_hcnt[2] == HC_W'(H_DISP - 1)) && (p_vcnt[2] == VC_W'(V_DISP - 1));

  always_comb begin
    hit = '0;
    for (int k = 0; k < N_CLASS; k++) begin
      hit[k] = active4 && !c_achrom && (c_mx >= p_rmin[2]) &&
               (hue_dist(c_hue, p_hue[2][9*k +: 9]) <= 9'(HUE_TOL));
    end
    code = '0;
    for (int k = N_CLASS - 1; k >= 0; k--) begin
      if (hit[k]) code = class_code_t'(k + 1);
    end
  end

  logic [CNT_W-1:0] cnt    [N_CLASS];
  logic [CNT_W-1:0] cnt_nx [N_CLASS];
  logic [CNT_W-1:0] st     [N_CLASS];
  logic             frame_seen;

  always_comb begin
    for (int k = 0; k < N_CLASS; k++) begin
      cnt_nx[k] = cnt[k];
      if ((code == class_code_t'(k + 1)) && (cnt[k] != '1)) cnt_nx[k] = cnt[k] + CNT_W'(1);
    end
  end

  // Statistics are only published for frames whose start was seen since reset.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      out_y      <= '0;
      out_hcnt   <= '0;
      out_vcnt   <= '0;
      stat_valid <= 1'b0;
      frame_seen <= 1'b0;
      for (int k = 0; k < N_CLASS; k++) begin
        cnt[k] <= '0;
        st[k]  <= '0;
      end
    end else begin
      out_y      <= code[CLASS_W-1:0];
      out_hcnt   <= p_hcnt[2];
      out_vcnt   <= p_vcnt[2];
      stat_valid <= 1'b0;
      if (sof4) frame_seen <= 1'b1;
      if (eof4) begin
        for (int k = 0; k < N_CLASS; k++) cnt[k] <= '0;
        if (frame_seen) begin
          for (int k = 0; k < N_CLASS; k++) st[k] <= cnt_nx[k];
          stat_valid <= 1'b1;
        end
      end else begin
        for (int k = 0; k < N_CLASS; k++) cnt[k] <= cnt_nx[k];
      end
    end
  end

  for (genvar k = 0; k < N_CLASS; k++) begin : g_stat
    assign stat_cnt[CNT_W*k +: CNT_W] = st[k];
  end

endmodule

// File: tb/tb_seg_hue_classifier.sv
// Directed bench for seg_hue_classifier on an 8x4 raster with a 6x3 active area.
module tb_seg_hue_classifier;

  localparam int LAT = 4;

  logic        clock;
  logic        n_rst;
  logic [23:0] in_y;
  logic [3:0]  in_hcnt;
  logic [2:0]  in_vcnt;
  logic [26:0] cfg_hue;
  logic [7:0]  cfg_rmin;
  logic [1:0]  out_y;
  logic [3:0]  out_hcnt;
  logic [2:0]  out_vcnt;
  logic [14:0] stat_cnt;
  logic        stat_valid;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  // Expected output word: {stat_valid, out_y[1:0], hcnt[3:0], vcnt[2:0]}
  logic [9:0] exp_q[$];

  seg_hue_classifier #(
    .WIDTH(8), .HEIGHT(4), .H_DISP(6), .V_DISP(3), .N_CLASS(3), .HUE_TOL(8)
  ) dut (
    .clock      (clock),
    .n_rst      (n_rst),
    .in_y       (in_y),
    .in_hcnt    (in_hcnt),
    .in_vcnt    (in_vcnt),
    .cfg_hue    (cfg_hue),
    .cfg_rmin   (cfg_rmin),
    .out_y      (out_y),
    .out_hcnt   (out_hcnt),
    .out_vcnt   (out_vcnt),
    .stat_cnt   (stat_cnt),
    .stat_valid (stat_valid)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, want);
    end
  endtask

  // Drive one pixel, advance one clock, compare the output of the pixel
  // driven LAT steps ago.
  task automatic step(input logic [23:0] pix, input int h, input int v, input int y, input bit sv);
    logic [9:0] e;
    in_y    = pix;
    in_hcnt = 4'(h);
    in_vcnt = 3'(v);
    exp_q.push_back({sv, 2'(y), 4'(h), 3'(v)});
    @(posedge clock);
    #1;
    step_no++;
    if (exp_q.size() == LAT) begin
      e = exp_q.pop_front();
      chk($sformatf("out_y[%0d]", step_no), 32'(out_y), 32'(e[8:7]));
      chk($sformatf("out_hcnt[%0d]", step_no), 32'(out_hcnt), 32'(e[6:3]));
      chk($sformatf("out_vcnt[%0d]", step_no), 32'(out_vcnt), 32'(e[2:0]));
      chk($sformatf("stat_valid[%0d]", step_no), 32'(stat_valid), 32'(e[9]));
    end
  endtask

  task automatic flush();
    for (int i = 0; i < LAT; i++) step(24'h000000, 7, 3, 0, 1'b0);
  endtask

  // Full raster of red pixels: class 1 on active area, end of frame at (5,2).
  task automatic red_frame(input bit expect_stat);
    for (int v = 0; v < 4; v++)
      for (int h = 0; h < 8; h++)
        step(24'hFF0000, h, v, (h < 6 && v < 3) ? 1 : 0, expect_stat && h == 5 && v == 2);
  endtask

  initial begin
    n_rst    = 1'b0;
    in_y     = '0;
    in_hcnt  = '0;
    in_vcnt  = '0;
    cfg_hue  = {9'd240, 9'd120, 9'd0};
    cfg_rmin = 8'd64;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_y", 32'(out_y), 0);
    chk("rst_out_hcnt", 32'(out_hcnt), 0);
    chk("rst_out_vcnt", 32'(out_vcnt), 0);
    chk("rst_stat_cnt", 32'(stat_cnt), 0);
    chk("rst_stat_valid", 32'(stat_valid), 0);
    n_rst = 1'b1;

    // Basic classes, thresholds, tolerance edges and one end of frame.
    step(24'hFF0000, 0, 0, 1, 1'b0);
    step(24'h00FF00, 1, 0, 2, 1'b0);
    step(24'h808080, 2, 0, 0, 1'b0);
    step(24'h300000, 3, 0, 0, 1'b0);
    step(24'h0000FF, 4, 0, 3, 1'b0);
    step(24'hFF0000, 5, 0, 1, 1'b0);
    step(24'hFF0000, 6, 0, 0, 1'b0);
    step(24'hFF0000, 0, 3, 0, 1'b0);
    step(24'hFFFF00, 1, 1, 0, 1'b0);
    step(24'hFF2200, 2, 1, 1, 1'b0);
    step(24'hFF2700, 3, 1, 0, 1'b0);
    step(24'h400000, 4, 1, 1, 1'b0);
    step(24'h3F0000, 5, 1, 0, 1'b0);
    step(24'hFF0000, 5, 2, 1, 1'b1);
    flush();
    chk("stat_first_frame", 32'(stat_cnt), 32'({5'd1, 5'd1, 5'd5}));

    // Hue wrap and mid-frame config changes.
    cfg_hue = {9'd240, 9'd120, 9'd355};
    step(24'hFF0010, 0, 0, 1, 1'b0);
    cfg_hue  = {9'd240, 9'd120, 9'd15};
    cfg_rmin = 8'd200;
    step(24'hFF4000, 1, 0, 0, 1'b0);
    step(24'hFF0010, 2, 0, 1, 1'b0);
    step(24'h800000, 3, 0, 1, 1'b0);
    step(24'hFF4000, 0, 0, 1, 1'b0);
    step(24'hFF0010, 1, 0, 0, 1'b0);
    step(24'h800000, 2, 0, 0, 1'b0);

    // Overlapping classes: lowest index wins.
    cfg_hue  = {9'd240, 9'd0, 9'd0};
    cfg_rmin = 8'd64;
    step(24'hFF0000, 0, 0, 1, 1'b0);
    step(24'hFF0800, 1, 0, 1, 1'b0);
    step(24'h0000FF, 2, 0, 3, 1'b0);
    step(24'h00FF00, 3, 0, 0, 1'b0);

    // Reset mid-frame with pixels still in flight.
    cfg_hue = {9'd240, 9'd120, 9'd0};
    n_rst = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_out_y", 32'(out_y), 0);
    chk("midrst_out_hcnt", 32'(out_hcnt), 0);
    chk("midrst_stat_cnt", 32'(stat_cnt), 0);
    chk("midrst_stat_valid", 32'(stat_valid), 0);
    repeat (2) @(posedge clock);
    #1;
    n_rst = 1'b1;

    // Tail of the interrupted frame runs on reset shadow (hue 0, rmin FF).
    for (int v = 1; v < 4; v++)
      for (int h = (v == 1) ? 2 : 0; h < 8; h++) begin
        if (h == 3 && v == 1) step(24'hFF0000, h, v, 1, 1'b0);
        else step(24'hFE0000, h, v, 0, 1'b0);
      end
    chk("stat_after_partial", 32'(stat_cnt), 0);

    red_frame(1'b1);
    red_frame(1'b1);
    flush();
    chk("stat_full_frame", 32'(stat_cnt), 32'({5'd0, 5'd0, 5'd18}));
    chk("stat_valid_idle", 32'(stat_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
